// File: rtl/seq_detector_param_pkg.sv
// Shared constants and helpers for the parametrised sequence detector.
// The default pattern reproduces the legacy fixed 8-symbol detector.
package seq_det_pkg;

  localparam int unsigned DEFAULT_DATA_W  = 3;
  localparam int unsigned DEFAULT_SEQ_LEN = 8;

  // Symbol 0 (first in time) sits in the least-significant DATA_W bits.
  localparam logic [DEFAULT_SEQ_LEN*DEFAULT_DATA_W-1:0] SEQ_DEFAULT =
    {3'b101, 3'b011, 3'b110, 3'b110, 3'b000, 3'b110, 3'b101, 3'b001};

  // Width needed to hold a fill level of 0..seq_len inclusive.
  function automatic int fill_width(input int seq_len);
    return $clog2(seq_len + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Symbol stream, pattern programming and status bundle of the sequence
// detector. The master drives stimulus; the detector is the slave.
interface seq_detector_param_if
  import seq_det_pkg::*;
#(
  parameter int DATA_W  = 3,
  parameter int SEQ_LEN = 8,
  parameter int CNT_W   = 8
);

  localparam int FILL_W = fill_width(SEQ_LEN);

  logic                      enable;
  logic                      data_valid;
  logic [DATA_W-1:0]         data;
  logic [SEQ_LEN*DATA_W-1:0] pattern;
  logic                      pattern_load;
  logic                      count_clear;
  logic                      sequence_found;
  logic [CNT_W-1:0]          match_count;
  logic [FILL_W-1:0]         fill_level;

  modport master (
    output enable, data_valid, data, pattern, pattern_load, count_clear,
    input  sequence_found, match_count, fill_level
  );

  modport slave (
    input  enable, data_valid, data, pattern, pattern_load, count_clear,
    output sequence_found, match_count, fill_level
  );

endinterface

// File: rtl/seq_detector_param_window_cmp.sv
// Combinational compare of the history window against the pattern,
// qualified by a full window.
module seq_window_cmp
  import seq_det_pkg::*;
#(
  parameter int DATA_W  = 3,
  parameter int SEQ_LEN = 8,
  localparam int FILL_W = fill_width(SEQ_LEN)
) (
  input  logic [SEQ_LEN*DATA_W-1:0] window,
  input  logic [SEQ_LEN*DATA_W-1:0] pattern,
  input  logic [FILL_W-1:0]         fill_level,
  output logic                      match
);

  logic all_eq;

  always_comb begin
    all_eq = 1'b1;
    for (int unsigned k = 0; k < SEQ_LEN; k++) begin
      if (window[k*DATA_W +: DATA_W] != pattern[k*DATA_W +: DATA_W]) begin
        all_eq = 1'b0;
      end
    end
    match = all_eq && (fill_level == FILL_W'(SEQ_LEN));
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable sequence detector: shifts qualified symbols into a
// history window, flags matches and keeps a saturating match count.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int DATA_W  = 3,
  parameter int SEQ_LEN = 8,
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  seq_detector_param_if.slave bus
);

  localparam int FILL_W = fill_width(SEQ_LEN);
  localparam int HIST_W = SEQ_LEN * DATA_W;

  logic [HIST_W-1:0] pattern_reg;
  logic [HIST_W-1:0] history;
  logic [HIST_W-1:0] history_next;
  logic [FILL_W-1:0] fill_level;
  logic [FILL_W-1:0] fill_inc;
  logic [FILL_W-1:0] fill_next;
  logic [CNT_W-1:0]  match_count;
  logic              found;
  logic              accept;
  logic              window_match;
  logic              match;

  always_comb begin
    accept       = bus.enable && bus.data_valid && !bus.pattern_load;
    // Newest symbol enters slot SEQ_LEN-1; slot 0 holds the oldest.
    history_next = {bus.data, history[HIST_W-1:DATA_W]};
    fill_inc     = (fill_level == FILL_W'(SEQ_LEN)) ? fill_level
                                                    : fill_level + FILL_W'(1);
  end

  seq_window_cmp #(
    .DATA_W  (DATA_W),
    .SEQ_LEN (SEQ_LEN)
  ) u_cmp (
    .window     (history_next),
    .pattern    (pattern_reg),
    .fill_level (fill_inc),
    .match      (window_match)
  );

  always_comb begin
    match     = accept && window_match;
    fill_next = (match && (OVERLAP == 0)) ? '0 : fill_inc;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pattern_reg <= '0;
      history     <= '0;
      fill_level  <= '0;
      found       <= 1'b0;
    end else if (bus.pattern_load) begin
      pattern_reg <= bus.pattern;
      history     <= '0;
      fill_level  <= '0;
      found       <= 1'b0;
    end else if (accept) begin
      history     <= history_next;
      fill_level  <= fill_next;
      found       <= match;
    end else begin
      found       <= 1'b0;
    end
  end

  // A clear in the same cycle as a match wins over the increment.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      match_count <= '0;
    end else if (bus.count_clear) begin
      match_count <= '0;
    end else if (match && (match_count != '1)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

  assign bus.sequence_found = found;
  assign bus.match_count    = match_count;
  assign bus.fill_level     = fill_level;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: stimulus pushes expected pulses, a monitor pops and
// compares on every sequence_found pulse of four differently sized detectors.
module tb_seq_detector_param;
  import seq_det_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  seq_detector_param_if #(.DATA_W(3), .SEQ_LEN(8), .CNT_W(8)) ifa ();
  seq_detector_param_if #(.DATA_W(2), .SEQ_LEN(3), .CNT_W(8)) ifb ();
  seq_detector_param_if #(.DATA_W(2), .SEQ_LEN(3), .CNT_W(8)) ifc ();
  seq_detector_param_if #(.DATA_W(2), .SEQ_LEN(3), .CNT_W(2)) ifd ();

  seq_detector_param #(.DATA_W(3), .SEQ_LEN(8), .OVERLAP(1), .CNT_W(8))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
  seq_detector_param #(.DATA_W(2), .SEQ_LEN(3), .OVERLAP(1), .CNT_W(8))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));
  seq_detector_param #(.DATA_W(2), .SEQ_LEN(3), .OVERLAP(0), .CNT_W(8))
    dut_c (.clk(clk), .reset_n(reset_n), .bus(ifc));
  seq_detector_param #(.DATA_W(2), .SEQ_LEN(3), .OVERLAP(1), .CNT_W(2))
    dut_d (.clk(clk), .reset_n(reset_n), .bus(ifd));

  typedef struct {
    int id;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [2:0] stream [8] = '{3'b001, 3'b101, 3'b110, 3'b000,
                             3'b110, 3'b110, 3'b011, 3'b101};

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int id, input int cnt);
    exp_t e;
    e.id  = id;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [3:0] f;
    int         c [4];
    exp_t       e;
    f    = {ifd.sequence_found, ifc.sequence_found,
            ifb.sequence_found, ifa.sequence_found};
    c[0] = int'(ifa.match_count);
    c[1] = int'(ifb.match_count);
    c[2] = int'(ifc.match_count);
    c[3] = int'(ifd.match_count);
    for (int i = 0; i < 4; i++) begin
      if (f[i]) begin
        if (exp_q.size() == 0) begin
          check($sformatf("spurious_pulse_dut%0d", i), int'(f[i]), 0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_dut_id", i, e.id);
          check($sformatf("pulse_count_dut%0d", i), c[i], e.cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [2:0] s);
    ifa.data       = s;
    ifa.data_valid = 1'b1;
    tick();
    ifa.data_valid = 1'b0;
  endtask

  task automatic a_load(input logic dv, input logic [2:0] s);
    ifa.pattern      = SEQ_DEFAULT;
    ifa.pattern_load = 1'b1;
    ifa.data_valid   = dv;
    ifa.data         = s;
    tick();
    ifa.pattern_load = 1'b0;
    ifa.data_valid   = 1'b0;
  endtask

  task automatic small_load();
    ifb.pattern = 6'b10_10_10; ifc.pattern = 6'b10_10_10; ifd.pattern = 6'b10_10_10;
    ifb.pattern_load = 1'b1; ifc.pattern_load = 1'b1; ifd.pattern_load = 1'b1;
    tick();
    ifb.pattern_load = 1'b0; ifc.pattern_load = 1'b0; ifd.pattern_load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    ifa.enable = 1'b1; ifa.data_valid = 1'b0; ifa.data = '0; ifa.pattern = '0;
    ifa.pattern_load = 1'b0; ifa.count_clear = 1'b0;
    ifb.enable = 1'b1; ifb.data_valid = 1'b0; ifb.data = '0; ifb.pattern = '0;
    ifb.pattern_load = 1'b0; ifb.count_clear = 1'b0;
    ifc.enable = 1'b1; ifc.data_valid = 1'b0; ifc.data = '0; ifc.pattern = '0;
    ifc.pattern_load = 1'b0; ifc.count_clear = 1'b0;
    ifd.enable = 1'b1; ifd.data_valid = 1'b0; ifd.data = '0; ifd.pattern = '0;
    ifd.pattern_load = 1'b0; ifd.count_clear = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    check("reset_found", int'(ifa.sequence_found), 0);
    check("reset_count", int'(ifa.match_count), 0);
    check("reset_fill", int'(ifa.fill_level), 0);
    check("reset_count_d", int'(ifd.match_count), 0);

    // Back-to-back default stream
    a_load(1'b0, 3'b000);
    check("load_fill", int'(ifa.fill_level), 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push_exp(0, 1);
      a_send(stream[i]);
    end
    tick(); tick();
    check("stream_count", int'(ifa.match_count), 1);
    check("stream_fill", int'(ifa.fill_level), 8);
    check("stream_pending", exp_q.size(), 0);

    // Gapped stream with one enable=0 cycle carrying a valid symbol
    a_load(1'b0, 3'b000);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        ifa.enable = 1'b0; ifa.data_valid = 1'b1; ifa.data = 3'b111;
        tick();
        ifa.enable = 1'b1; ifa.data_valid = 1'b0;
      end
      if (i == 7) push_exp(0, 2);
      a_send(stream[i]);
      repeat (3) tick();
    end
    check("gap_count", int'(ifa.match_count), 2);
    check("gap_fill", int'(ifa.fill_level), 8);
    check("gap_pending", exp_q.size(), 0);

    // Reset in the middle of a partial match
    a_load(1'b0, 3'b000);
    for (int i = 0; i < 3; i++) a_send(stream[i]);
    check("partial_fill", int'(ifa.fill_level), 3);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midreset_found", int'(ifa.sequence_found), 0);
    check("midreset_count", int'(ifa.match_count), 0);
    check("midreset_fill", int'(ifa.fill_level), 0);
    for (int i = 3; i < 8; i++) a_send(stream[i]);
    tick(); tick();
    check("postreset_fill", int'(ifa.fill_level), 5);
    check("postreset_count", int'(ifa.match_count), 0);

    // pattern_load with a concurrent valid symbol drops that symbol
    a_load(1'b0, 3'b000);
    for (int i = 0; i < 3; i++) a_send(stream[i]);
    a_load(1'b1, stream[3]);
    check("load_drop_fill", int'(ifa.fill_level), 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push_exp(0, 1);
      a_send(stream[i]);
    end
    tick(); tick();
    check("reload_count", int'(ifa.match_count), 1);
    check("reload_pending", exp_q.size(), 0);

    // Overlap vs non-overlap on a 3-symbol pattern of 2s
    small_load();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin push_exp(1, 1); push_exp(2, 1); end
      if (i == 3) push_exp(1, 2);
      if (i == 4) push_exp(1, 3);
      ifb.data = 2'd2; ifc.data = 2'd2;
      ifb.data_valid = 1'b1; ifc.data_valid = 1'b1;
      tick();
      ifb.data_valid = 1'b0; ifc.data_valid = 1'b0;
    end
    tick(); tick();
    check("ovl_count", int'(ifb.match_count), 3);
    check("ovl_fill", int'(ifb.fill_level), 3);
    check("novl_count", int'(ifc.match_count), 1);
    check("novl_fill", int'(ifc.fill_level), 2);
    check("ovl_pending", exp_q.size(), 0);

    // Saturating 2-bit counter, then clear coincident with a match
    for (int i = 0; i < 7; i++) begin
      if (i == 2) push_exp(3, 1);
      if (i == 3) push_exp(3, 2);
      if (i == 4) push_exp(3, 3);
      if (i == 5) push_exp(3, 3);
      if (i == 6) push_exp(3, 0);
      ifd.data = 2'd2;
      ifd.data_valid = 1'b1;
      ifd.count_clear = (i == 6);
      tick();
      ifd.data_valid = 1'b0;
      ifd.count_clear = 1'b0;
    end
    tick(); tick();
    check("sat_clear_count", int'(ifd.match_count), 0);
    check("sat_fill", int'(ifd.fill_level), 3);
    check("sat_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised successor to the fixed 8-symbol sequence detector.
- Matches a runtime-programmable pattern of SEQ_LEN symbols, each DATA_W bits wide, against a qualified input stream.
- Matches may overlap or not, selected by parameter. Matches are counted in a saturating counter.
- Sits on the symbol stream after the input capture stage and feeds the status/interrupt logic.

Parameters:
- DATA_W, 3, width of one symbol in bits (>=1)
- SEQ_LEN, 8, pattern length in symbols (2..32)
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history cleared after each match
- CNT_W, 8, width of the match counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- enable  in  1  1 = detector accepts symbols; 0 = history and outputs hold
- data_valid  in  1  qualifies data for the current cycle
- data  in  DATA_W  input symbol
- pattern  in  SEQ_LEN*DATA_W  target pattern; symbol k at bits [k*DATA_W +: DATA_W]; symbol 0 is the first in time
- pattern_load  in  1  1-cycle strobe: latch pattern and clear history
- sequence_found  out  1  registered 1-cycle pulse per match
- match_count  out  CNT_W  number of matches since reset or clear, saturating
- fill_level  out  $clog2(SEQ_LEN+1)  valid symbols in history (0..SEQ_LEN)
- count_clear  in  1  1-cycle strobe: zero match_count

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - pattern register = 0, history = 0, fill_level = 0, sequence_found = 0, match_count = 0.
  - Reset has priority over all other inputs and may abort a partial match at any time.
  - Until the first pattern_load, the pattern register is all-zero.
- Accept: a symbol is accepted when enable=1, data_valid=1, and pattern_load=0.
  - History is a SEQ_LEN-deep shift register; the newest symbol goes in slot SEQ_LEN-1 and the oldest sits in slot 0.
  - On accept, fill_level increments and saturates at SEQ_LEN.
- Match:
  - Evaluated on the post-shift window.
  - Condition: fill_level_next == SEQ_LEN and history_next[k] == pattern_reg[k] for every k.
- Latency: sequence_found is high for exactly the one cycle following the clk edge that accepted the final symbol of the match. It is 0 in all other cycles.
- On match:
  - If CNT_W-bit match_count is below its all-ones value, it increments by 1; at all-ones it holds.
  - OVERLAP=0: fill_level is forced to 0, so the next match needs SEQ_LEN fresh symbols.
  - OVERLAP=1: fill_level stays SEQ_LEN, so a match can fire on every accept.
- Cycles with enable=0 or data_valid=0: no shift, history and fill_level hold, sequence_found = 0. Idle gaps do not break a partial match.
- pattern_load=1:
  - Captures pattern, sets fill_level = 0 and history = 0, and sets sequence_found = 0 for the next cycle.
  - A data_valid asserted in the same cycle is dropped.
- count_clear=1:
  - match_count = 0.
  - If a match occurs in the same cycle, clear wins and the count ends at 0. sequence_found still pulses.
- enable=0 has no effect on pattern_load or count_clear.
- Mismatch: no explicit state reset is needed. The sliding window re-aligns naturally, so a mismatching symbol can still begin a new match.

Decomposition:
- Package seq_det_pkg holds:
  - default pattern constant SEQ_DEFAULT = {101,011,110,110,000,110,101,001} (symbol 0 = 001);
  - a function for fill_level width.
- Sub-module seq_window_cmp: combinational compare of window against pattern with a fill_level qualifier. Parametrised by DATA_W and SEQ_LEN; outputs match.
- Top-level owns history, counters and all registers.

Test Plan:
- Defaults, pattern_load SEQ_DEFAULT, then stream 001,101,110,000,110,110,011,101 with data_valid=1 -> sequence_found pulses once, in the cycle after the 8th symbol; match_count=1; fill_level=8.
- Same stream with data_valid=0 gaps of 3 cycles between symbols, plus one enable=0 cycle -> single pulse after the last accepted symbol; no spurious pulse during gaps.
- SEQ_LEN=3, DATA_W=2, pattern {2,2,2}, feed 2 five times:
  - OVERLAP=1 -> pulses after symbols 3, 4 and 5; match_count=3.
  - OVERLAP=0 -> one pulse after symbol 3; match_count=1; fill_level=2 at end.
- Partial stream 001,101,110, reset_n=0 for 1 cycle, then the remaining 5 symbols -> no pulse; all outputs 0 after reset.
- Same partial stream then pattern_load with data_valid=1 in that cycle -> fill_level=0 and the concurrent symbol is dropped.
- CNT_W=2, 4 back-to-back matches -> match_count 1,2,3,3 (saturates).
- count_clear coincident with the 5th match -> count 0, and sequence_found still pulses.
